// File: rtl/vote_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vote_pkg
//  Description : Shared types and constants for the four-voter ballot
//                session controller and its verdict classifier.
//  Revision    : 1.0  initial release
// ============================================================================
package vote_pkg;

    // Session controller states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OPEN   = 2'd1,
        ST_TALLY  = 2'd2,
        ST_RESULT = 2'd3
    } state_e;

    // One-hot verdict encodings
    localparam logic [2:0] RES_LOW  = 3'b100;   // 0-1 yes votes
    localparam logic [2:0] RES_TIE  = 3'b010;   // exactly 2 yes votes
    localparam logic [2:0] RES_HIGH = 3'b001;   // 3-4 yes votes

    localparam int unsigned TIMEOUT_DEFAULT = 16;

    // Width of a down-counter that must hold values up to timeout
    function automatic int unsigned timer_width(input int unsigned timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage : vote_pkg
`default_nettype wire

// File: rtl/vote_classify.sv
`default_nettype none
// ============================================================================
//  Module      : vote_classify
//  Description : Combinational classifier turning a 4-bit yes vector into
//                a one-hot low / tie / high verdict.
//  Revision    : 1.0  initial release
// ============================================================================
module vote_classify
    import vote_pkg::*;
(
    input  logic [3:0] yes_i,
    output logic [2:0] verdict_o
);

    logic [2:0] yes_cnt;

    // Population count of the yes vector
    always_comb begin
        yes_cnt = 3'd0;
        for (int i = 0; i < 4; i++) begin
            yes_cnt = yes_cnt + {2'b00, yes_i[i]};
        end
    end

    // Map the yes count onto the one-hot verdict
    always_comb begin
        if (yes_cnt <= 3'd1) begin
            verdict_o = RES_LOW;
        end else if (yes_cnt == 3'd2) begin
            verdict_o = RES_TIE;
        end else begin
            verdict_o = RES_HIGH;
        end
    end

endmodule : vote_classify
`default_nettype wire

// File: rtl/vote_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : vote_session_ctrl
//  Description : Runs one four-voter ballot session: opens on start, latches
//                the first vote of each voter, closes on all-voted / close /
//                timeout, and holds a registered verdict until acknowledged.
//  Revision    : 1.0  initial release
// ============================================================================
module vote_session_ctrl
    import vote_pkg::*;
#(
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       close,
    input  logic [3:0] vote_valid,
    input  logic [3:0] vote_yes,
    input  logic       result_ack,
    output logic       busy,
    output logic [3:0] voted,
    output logic [2:0] result,
    output logic       result_valid,
    output logic       timed_out
);

    localparam int unsigned    TW       = timer_width(TIMEOUT);
    localparam logic [TW-1:0]  TMR_LOAD = TW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    voted_q, voted_d;
    logic [3:0]    yes_q, yes_d;
    logic [2:0]    result_q, result_d;
    logic          timed_out_q, timed_out_d;

    logic [3:0]    accept;
    logic          all_voted;
    logic          timer_zero;
    logic [2:0]    verdict;

    vote_classify u_classify (
        .yes_i     (yes_q),
        .verdict_o (verdict)
    );

    // Votes this cycle that come from voters who have not yet voted
    assign accept     = vote_valid & ~voted_q;
    assign all_voted  = ((voted_q | accept) == 4'hF);
    assign timer_zero = (timer_q == '0);

    // Next-state and datapath update for the session FSM
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        voted_d     = voted_q;
        yes_d       = yes_q;
        result_d    = result_q;
        timed_out_d = timed_out_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_OPEN;
                    timer_d     = TMR_LOAD;
                    voted_d     = 4'h0;
                    yes_d       = 4'h0;
                    timed_out_d = 1'b0;
                end
            end
            ST_OPEN: begin
                // Votes landing in the closing cycle still count
                voted_d = voted_q | accept;
                yes_d   = yes_q | (accept & vote_yes);
                if (!timer_zero) begin
                    timer_d = timer_q - TW'(1);
                end
                if (all_voted || close || timer_zero) begin
                    state_d     = ST_TALLY;
                    timed_out_d = timer_zero && !all_voted && !close;
                end
            end
            ST_TALLY: begin
                result_d = verdict;
                state_d  = ST_RESULT;
            end
            ST_RESULT: begin
                if (result_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            timer_q     <= '0;
            voted_q     <= 4'h0;
            yes_q       <= 4'h0;
            result_q    <= 3'b000;
            timed_out_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            timer_q     <= timer_d;
            voted_q     <= voted_d;
            yes_q       <= yes_d;
            result_q    <= result_d;
            timed_out_q <= timed_out_d;
        end
    end

    assign busy         = (state_q == ST_OPEN) || (state_q == ST_TALLY);
    assign result_valid = (state_q == ST_RESULT);
    assign voted        = voted_q;
    assign result       = result_q;
    assign timed_out    = timed_out_q;

endmodule : vote_session_ctrl
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vote_session_ctrl
//  Description : Randomised and directed bench for vote_session_ctrl with a
//                session-level reference model and a verdict scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vote_session_ctrl;

    localparam int TO = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       close = 1'b0;
    logic [3:0] vote_valid = 4'h0;
    logic [3:0] vote_yes = 4'h0;
    logic       result_ack = 1'b0;
    logic       busy;
    logic [3:0] voted;
    logic [2:0] result;
    logic       result_valid;
    logic       timed_out;

    vote_session_ctrl #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .close        (close),
        .vote_valid   (vote_valid),
        .vote_yes     (vote_yes),
        .result_ack   (result_ack),
        .busy         (busy),
        .voted        (voted),
        .result       (result),
        .result_valid (result_valid),
        .timed_out    (timed_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] res;
        logic       to;
        int         k;
        logic [3:0] voted;
        int         cyc;
    } exp_t;

    exp_t sb[$];

    // Per-OPEN-cycle stimulus of one session
    logic [3:0] tv [TO];
    logic [3:0] ty [TO];
    logic       tc [TO];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Session-level reference: first vote per voter stands, the session ends
    // at the first cycle with everyone voted, a close, or the last timed cycle.
    function automatic exp_t model();
        exp_t       e;
        logic [3:0] v = 4'h0;
        logic [3:0] y = 4'h0;
        int         nyes;
        e.k  = TO - 1;
        e.to = 1'b0;
        for (int c = 0; c < TO; c++) begin
            for (int i = 0; i < 4; i++) begin
                if (tv[c][i] && !v[i]) begin
                    v[i] = 1'b1;
                    y[i] = ty[c][i];
                end
            end
            if (v == 4'hF || tc[c] || c == TO - 1) begin
                e.k  = c;
                e.to = (c == TO - 1) && (v != 4'hF) && !tc[c];
                break;
            end
        end
        nyes = 0;
        for (int i = 0; i < 4; i++) nyes += int'(y[i]);
        e.res   = (nyes <= 1) ? 3'b100 : (nyes == 2) ? 3'b010 : 3'b001;
        e.voted = v;
        return e;
    endfunction

    task automatic drive(input logic s, input logic cl, input logic [3:0] vv,
                         input logic [3:0] vy, input logic ack);
        start      = s;
        close      = cl;
        vote_valid = vv;
        vote_yes   = vy;
        result_ack = ack;
        @(posedge clk);
        #1;
    endtask

    task automatic junk(input logic allow_start);
        drive(allow_start & $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0,
              4'($urandom), 4'($urandom), 1'b0);
    endtask

    task automatic clear_trace();
        for (int c = 0; c < TO; c++) begin
            tv[c] = 4'h0;
            ty[c] = 4'h0;
            tc[c] = 1'b0;
        end
    endtask

    task automatic rand_trace();
        for (int c = 0; c < TO; c++) begin
            tv[c] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            ty[c] = 4'($urandom);
            tc[c] = ($urandom_range(0, 11) == 0);
        end
    endtask

    task automatic run_session();
        exp_t       e;
        logic [3:0] cur = 4'h0;
        bit         seen = 0;
        e = model();
        // Votes and close in the start cycle arrive while still IDLE
        drive(1'b1, $urandom_range(0, 1) == 0, 4'($urandom), 4'($urandom), 1'b0);
        e.cyc = cyc + e.k + 2;
        sb.push_back(e);
        chk("busy_after_start", 32'(busy), 32'd1);
        chk("voted_clear_at_open", 32'(voted), 32'd0);
        for (int c = 0; c <= e.k; c++) begin
            drive($urandom_range(0, 1) == 0, tc[c], tv[c], ty[c], $urandom_range(0, 1) == 0);
            cur |= tv[c];
            if (c < e.k) begin
                chk("busy_open", 32'(busy), 32'd1);
                chk("voted_open", 32'(voted), 32'(cur));
            end
        end
        for (int w = 0; w < 6; w++) begin
            if (result_valid) begin
                seen = 1;
                break;
            end
            junk(1'b1);
        end
        if (!seen) begin
            chk("result_valid_timeout", 32'(result_valid), 32'd1);
            if (sb.size() != 0) void'(sb.pop_front());
        end
        repeat ($urandom_range(0, 2)) junk(1'b1);
        // Acknowledge with a simultaneous start, which must be ignored
        drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b1);
        chk("rv_after_ack", 32'(result_valid), 32'd0);
        chk("busy_after_ack", 32'(busy), 32'd0);
        drive(1'b0, $urandom_range(0, 1) == 0, 4'($urandom), 4'($urandom), 1'b0);
        chk("idle_holds", 32'(busy), 32'd0);
    endtask

    // Scoreboard monitor: compares each verdict as it appears
    logic prev_rv = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_rv = 1'b0;
        end else begin
            if (result_valid && !prev_rv) begin
                if (sb.size() == 0) begin
                    chk("unexpected_verdict", 32'(result_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("result", 32'(result), 32'(e.res));
                    chk("timed_out", 32'(timed_out), 32'(e.to));
                    chk("verdict_latency", 32'(cyc), 32'(e.cyc));
                    chk("voted_final", 32'(voted), 32'(e.voted));
                    chk("busy_in_result", 32'(busy), 32'd0);
                end
            end
            prev_rv = result_valid;
        end
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_voted", 32'(voted), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_rv", 32'(result_valid), 32'd0);
        chk("rst_timed_out", 32'(timed_out), 32'd0);
        rst = 1'b0;
        junk(1'b0);
        junk(1'b0);
        chk("idle_ignores", 32'(busy), 32'd0);

        // All four vote yes at once
        clear_trace();
        tv[0] = 4'hF; ty[0] = 4'hF;
        run_session();

        // Two yes, then two no on a later cycle
        clear_trace();
        tv[0] = 4'b0011; ty[0] = 4'b0011;
        tv[2] = 4'b1100; ty[2] = 4'b0000;
        run_session();

        // Only voter 0 votes: pure timeout
        clear_trace();
        tv[0] = 4'b0001; ty[0] = 4'b0001;
        run_session();

        // Voter 2 repeats with a different value; first vote stands
        clear_trace();
        tv[0] = 4'b0100; ty[0] = 4'b0100;
        tv[1] = 4'b0100; ty[1] = 4'b0000;
        tv[2] = 4'b1111; ty[2] = 4'b0000;
        run_session();

        // Close in the same cycle as the 2nd and 3rd yes votes
        clear_trace();
        tv[0] = 4'b0001; ty[0] = 4'b0001;
        tv[3] = 4'b0110; ty[3] = 4'b0110; tc[3] = 1'b1;
        run_session();

        // Asynchronous reset in the middle of a session
        drive(1'b1, 1'b0, 4'h0, 4'h0, 1'b0);
        drive(1'b0, 1'b0, 4'b0101, 4'b0001, 1'b0);
        drive(1'b0, 1'b0, 4'h0, 4'h0, 1'b0);
        chk("pre_rst_voted", 32'(voted), 32'b0101);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_voted", 32'(voted), 32'd0);
        chk("mid_rst_rv", 32'(result_valid), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        clear_trace();
        tv[1] = 4'hF; ty[1] = 4'b1010;
        run_session();

        for (int s = 0; s < 25; s++) begin
            rand_trace();
            run_session();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_vote_session_ctrl
`default_nettype wire
